// File: rtl/pio_tx_snoop_if.sv
// PCIe AXIS TX TLP stream bundle between the snoop engine (master) and the PCIe core (slave).
interface pio_tx_snoop_if;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;
  logic        s_axis_tx_tready;
  logic [3:0]  s_axis_tx_tuser;

  modport master (
    output s_axis_tx_tdata,
    output s_axis_tx_tkeep,
    output s_axis_tx_tlast,
    output s_axis_tx_tvalid,
    output s_axis_tx_tuser,
    input  s_axis_tx_tready
  );

  modport slave (
    input  s_axis_tx_tdata,
    input  s_axis_tx_tkeep,
    input  s_axis_tx_tlast,
    input  s_axis_tx_tvalid,
    input  s_axis_tx_tuser,
    output s_axis_tx_tready
  );
endinterface

// File: rtl/pio_tx_snoop.sv
// Snoops XGMII-RX words from a FWFT FIFO and posts each 64-bit data word as a 2-DW MWr32 TLP.
// Optional macro PIO_TX_SNOOP_COUNT_EN adds a 32-bit count of posted TLPs (tlp_count).
module pio_tx_snoop #(
  parameter int WINDOW_BYTES = 4096
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  pio_tx_snoop_if.master       tx,
  input  logic [15:0]          cfg_completer_id,
  input  logic                 tx_enable,
  input  logic [31:0]          dest_base,
  input  logic [71:0]          dout,
  input  logic                 empty,
`ifdef PIO_TX_SNOOP_COUNT_EN
  output logic [31:0]          tlp_count,
`endif
  output logic                 rd_en
);

  localparam int OffW = $clog2(WINDOW_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    FRAME,
    HDR0,
    HDR1,
    PAY
  } state_t;

  state_t            state_q;
  logic              en_q;
  logic [63:0]       payload_q;
  logic [OffW-1:0]   offset_q;
  logic [7:0]        tag_q;
  logic [63:0]       tdata_q;
  logic [7:0]        tkeep_q;
  logic              tlast_q;
  logic              tvalid_q;

  logic [7:0]        wordCtrl;
  logic [63:0]       wordData;
  logic              isStart;
  logic              isData;
  logic              beatTaken;
  logic [OffW-1:0]   offset_d;
  logic [31:0]       addr_d;

  assign wordCtrl  = dout[71:64];
  assign wordData  = dout[63:0];
  assign isStart   = wordCtrl[0] && (wordData[7:0] == 8'hFB);
  assign isData    = (wordCtrl == 8'h00);
  assign beatTaken = tvalid_q && tx.s_axis_tx_tready;

  // The offset register is exactly log2(window) bits wide, so the +8 step wraps on its own.
  assign offset_d = offset_q + OffW'(8);
  assign addr_d   = (dest_base + 32'(offset_q)) & 32'hFFFF_FFFC;

  assign rd_en = !sys_rst && !empty && ((state_q == IDLE) || (state_q == FRAME));

  assign tx.s_axis_tx_tdata  = tdata_q;
  assign tx.s_axis_tx_tkeep  = tkeep_q;
  assign tx.s_axis_tx_tlast  = tlast_q;
  assign tx.s_axis_tx_tvalid = tvalid_q;
  assign tx.s_axis_tx_tuser  = 4'h0;

`ifdef PIO_TX_SNOOP_COUNT_EN
  logic [31:0] tlp_count_q;
  assign tlp_count = tlp_count_q;
`endif

  // Each beat is loaded into the output registers on the transition into its state, so it
  // stays frozen while the core back-pressures.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      payload_q   <= '0;
      offset_q    <= '0;
      tag_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
`ifdef PIO_TX_SNOOP_COUNT_EN
      tlp_count_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty && isStart) begin
            en_q    <= tx_enable;
            state_q <= FRAME;
          end
        end
        FRAME: begin
          if (!empty) begin
            if (isStart) begin
              en_q <= tx_enable;
            end else if (isData) begin
              if (en_q) begin
                payload_q <= wordData;
                tdata_q   <= {cfg_completer_id, tag_q, 8'hFF, 32'h4000_0002};
                tkeep_q   <= 8'hFF;
                tlast_q   <= 1'b0;
                tvalid_q  <= 1'b1;
                state_q   <= HDR0;
              end
            end else begin
              state_q <= IDLE;
            end
          end
        end
        HDR0: begin
          if (beatTaken) begin
            tdata_q <= {payload_q[31:0], addr_d};
            state_q <= HDR1;
          end
        end
        HDR1: begin
          if (beatTaken) begin
            tdata_q <= {32'h0, payload_q[63:32]};
            tkeep_q <= 8'h0F;
            tlast_q <= 1'b1;
            state_q <= PAY;
          end
        end
        PAY: begin
          if (beatTaken) begin
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            offset_q    <= offset_d;
            tag_q       <= tag_q + 8'd1;
`ifdef PIO_TX_SNOOP_COUNT_EN
            tlp_count_q <= tlp_count_q + 32'd1;
`endif
            state_q     <= FRAME;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_tx_snoop.sv
// Randomized self-checking bench for pio_tx_snoop: two instances (4096- and 16-byte windows)
// share one FIFO feed and are compared against a frame-level reference model.
module tb_pio_tx_snoop;

  localparam int WinA = 4096;
  localparam int WinB = 16;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [15:0] cfg_completer_id;
  logic        tx_enable;
  logic [31:0] dest_base;
  logic [71:0] dout;
  logic        empty;
  logic        tready;
  logic        rdEnA;
  logic        rdEnB;
`ifdef PIO_TX_SNOOP_COUNT_EN
  logic [31:0] tlpCountA;
  logic [31:0] tlpCountB;
`endif

  always #5 clk = ~clk;

  pio_tx_snoop_if ifA ();
  pio_tx_snoop_if ifB ();
  assign ifA.s_axis_tx_tready = tready;
  assign ifB.s_axis_tx_tready = tready;

  pio_tx_snoop #(.WINDOW_BYTES(WinA)) dutA (
    .clk              (clk),
    .sys_rst          (sys_rst),
    .tx               (ifA),
    .cfg_completer_id (cfg_completer_id),
    .tx_enable        (tx_enable),
    .dest_base        (dest_base),
    .dout             (dout),
    .empty            (empty),
`ifdef PIO_TX_SNOOP_COUNT_EN
    .tlp_count        (tlpCountA),
`endif
    .rd_en            (rdEnA)
  );

  pio_tx_snoop #(.WINDOW_BYTES(WinB)) dutB (
    .clk              (clk),
    .sys_rst          (sys_rst),
    .tx               (ifB),
    .cfg_completer_id (cfg_completer_id),
    .tx_enable        (tx_enable),
    .dest_base        (dest_base),
    .dout             (dout),
    .empty            (empty),
`ifdef PIO_TX_SNOOP_COUNT_EN
    .tlp_count        (tlpCountB),
`endif
    .rd_en            (rdEnB)
  );

  typedef struct {
    logic [71:0] word;
    logic        en;
  } fifo_t;

  typedef struct {
    logic [63:0] dataA;
    logic [63:0] dataB;
    logic [7:0]  keep;
    logic        last;
    int          idx;
  } beat_t;

  int          checkCount = 0;
  int          errorCount = 0;
  fifo_t       fifoQ[$];
  beat_t       expQ[$];
  logic [31:0] destArr[$];
  int          tlpIdx = 0;
  int          tlpDone = 0;
  bit          mInFrame = 0;
  bit          mEn = 0;
  int          bubblePct = 0;
  int          readyMode = 0;
  int          stallLeft = 0;
  bit          resetOnPay = 0;
  bit          useFixedDest = 0;
  logic [31:0] fixedDest = 32'h0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic void pushWord(input logic [71:0] w, input logic en);
    fifo_t f;
    f.word = w;
    f.en   = en;
    fifoQ.push_back(f);
  endfunction

  function automatic void clearModel();
    fifoQ.delete();
    expQ.delete();
    destArr.delete();
    tlpIdx   = 0;
    tlpDone  = 0;
    mInFrame = 0;
    mEn      = 0;
  endfunction

  // TLP n goes to dest + (8n mod window), DW aligned, with tag n mod 256.
  function automatic void genTlp(input logic [63:0] d);
    logic [31:0] dest;
    logic [31:0] addrA;
    logic [31:0] addrB;
    logic [7:0]  tag;
    beat_t       b;
    dest  = useFixedDest ? fixedDest : $urandom;
    destArr.push_back(dest);
    tag   = 8'(tlpIdx % 256);
    addrA = (dest + 32'((tlpIdx * 8) % WinA)) & 32'hFFFF_FFFC;
    addrB = (dest + 32'((tlpIdx * 8) % WinB)) & 32'hFFFF_FFFC;
    b.dataA = {cfg_completer_id, tag, 8'hFF, 32'h4000_0002};
    b.dataB = b.dataA;
    b.keep  = 8'hFF;
    b.last  = 1'b0;
    b.idx   = 0;
    expQ.push_back(b);
    b.dataA = {d[31:0], addrA};
    b.dataB = {d[31:0], addrB};
    b.idx   = 1;
    expQ.push_back(b);
    b.dataA = {32'h0, d[63:32]};
    b.dataB = b.dataA;
    b.keep  = 8'h0F;
    b.last  = 1'b1;
    b.idx   = 2;
    expQ.push_back(b);
    tlpIdx++;
  endfunction

  function automatic void modelPop(input fifo_t f);
    logic [7:0]  c;
    logic [63:0] d;
    bit          isStart;
    bit          isData;
    c       = f.word[71:64];
    d       = f.word[63:0];
    isStart = c[0] && (d[7:0] == 8'hFB);
    isData  = (c == 8'h00);
    if (!mInFrame) begin
      if (isStart) begin
        mInFrame = 1;
        mEn      = f.en;
      end
    end else if (isStart) begin
      mEn = f.en;
    end else if (isData) begin
      if (mEn) genTlp(d);
    end else begin
      mInFrame = 0;
    end
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tvalid"}, 64'(ifA.s_axis_tx_tvalid), 64'd0);
    checkOutput({tag, "_tlast"}, 64'(ifA.s_axis_tx_tlast), 64'd0);
    checkOutput({tag, "_tkeep"}, 64'(ifA.s_axis_tx_tkeep), 64'd0);
    checkOutput({tag, "_tdata"}, ifA.s_axis_tx_tdata, 64'd0);
    checkOutput({tag, "_rd_en"}, 64'(rdEnA), 64'd0);
    checkOutput({tag, "_tvalid_w16"}, 64'(ifB.s_axis_tx_tvalid), 64'd0);
  endtask

  task automatic stepCycle();
    bit bubble;
    bit expRd;
    @(negedge clk);
    bubble = ($urandom_range(0, 99) < bubblePct);
    if (fifoQ.size() != 0 && !bubble) begin
      empty     = 1'b0;
      dout      = fifoQ[0].word;
      tx_enable = fifoQ[0].en;
    end else begin
      empty     = 1'b1;
      dout      = {8'($urandom), $urandom, $urandom};
      tx_enable = 1'($urandom);
    end
    dest_base = (tlpDone < destArr.size()) ? destArr[tlpDone] : $urandom;
    case (readyMode)
      0: tready = 1'b1;
      1: tready = ($urandom_range(0, 3) != 0);
      default: begin
        tready = !(expQ.size() != 0 && expQ[0].idx == 1 && stallLeft > 0);
        if (!tready) stallLeft--;
      end
    endcase
    #1;
    expRd = !empty && (expQ.size() == 0);
    checkOutput("rd_en", 64'(rdEnA), 64'(expRd));
    checkOutput("rd_en_w16", 64'(rdEnB), 64'(expRd));
    checkOutput("tvalid", 64'(ifA.s_axis_tx_tvalid), 64'(expQ.size() != 0));
    checkOutput("tvalid_w16", 64'(ifB.s_axis_tx_tvalid), 64'(expQ.size() != 0));
    checkOutput("tuser", 64'(ifA.s_axis_tx_tuser), 64'd0);
`ifdef PIO_TX_SNOOP_COUNT_EN
    checkOutput("tlp_count", 64'(tlpCountA), 64'(tlpDone));
`endif
    if (expQ.size() != 0) begin
      checkOutput("tdata", ifA.s_axis_tx_tdata, expQ[0].dataA);
      checkOutput("tdata_w16", ifB.s_axis_tx_tdata, expQ[0].dataB);
      checkOutput("tkeep", 64'(ifA.s_axis_tx_tkeep), 64'(expQ[0].keep));
      checkOutput("tlast", 64'(ifA.s_axis_tx_tlast), 64'(expQ[0].last));
    end
    if (resetOnPay && expQ.size() != 0 && expQ[0].idx == 2) begin
      sys_rst = 1'b1;
      #1;
      checkResetOutputs("rst_in_pay");
      clearModel();
      resetOnPay = 0;
      @(posedge clk);
      #1;
      sys_rst = 1'b0;
      return;
    end
    if (expQ.size() != 0 && tready) begin
      if (expQ[0].idx == 0) stallLeft = 5;
      if (expQ[0].last) tlpDone++;
      void'(expQ.pop_front());
    end else if (expRd) begin
      modelPop(fifoQ.pop_front());
    end
  endtask

  task automatic runUntilDrained(input int maxCycles);
    int n = 0;
    while ((fifoQ.size() != 0 || expQ.size() != 0) && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_timeout", 64'(fifoQ.size() + expQ.size()), 64'd0);
    repeat (3) stepCycle();
  endtask

  task automatic applyReset();
    @(negedge clk);
    sys_rst = 1'b1;
    empty   = 1'b0;
    dout    = {8'hFF, 64'h0707_0707_0707_0707};
    #1;
    checkResetOutputs("reset");
`ifdef PIO_TX_SNOOP_COUNT_EN
    checkOutput("reset_tlp_count", 64'(tlpCountA), 64'd0);
`endif
    clearModel();
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  // One frame: START, nData DATA words, terminate. With randEn the enable seen on DATA words toggles.
  task automatic applyStimulus(input int nData, input logic en, input bit randEn);
    pushWord({8'h01, 56'h55_5555_5555_5555, 8'hFB}, en);
    for (int i = 0; i < nData; i++) begin
      pushWord({8'h00, $urandom, $urandom}, randEn ? 1'($urandom) : en);
    end
    pushWord({8'hFF, 64'h0707_0707_0707_07FD}, randEn ? 1'($urandom) : en);
  endtask

  task automatic pushRandomWord();
    int          k;
    logic [7:0]  c;
    logic [63:0] d;
    k = $urandom_range(0, 9);
    d = {$urandom, $urandom};
    if (k < 2) begin
      c = 8'($urandom) | 8'h01;
      d[7:0] = 8'hFB;
    end else if (k < 8) begin
      c = 8'h00;
    end else begin
      c = 8'($urandom_range(1, 255));
      if (c[0] && d[7:0] == 8'hFB) d[7:0] = 8'hFD;
    end
    pushWord({c, d}, 1'($urandom));
  endtask

  initial begin
    sys_rst          = 1'b1;
    tready           = 1'b1;
    tx_enable        = 1'b0;
    dest_base        = 32'h0;
    cfg_completer_id = 16'h0100;
    empty            = 1'b0;
    dout             = {8'hFF, 64'h0707_0707_0707_0707};
    applyReset();

    // Idle stream: every word popped, nothing transmitted.
    for (int i = 0; i < 16; i++) pushWord({8'hFF, 64'h0707_0707_0707_0707}, 1'($urandom));
    runUntilDrained(200);

    // Directed frame with the reference header values.
    useFixedDest = 1;
    fixedDest    = 32'h8000_0000;
    pushWord({8'h01, 56'h55_5555_5555_5555, 8'hFB}, 1'b1);
    pushWord({8'h00, 64'h1122_3344_5566_7788}, 1'b1);
    pushWord({8'hFF, 64'h0707_0707_0707_07FD}, 1'b1);
    runUntilDrained(200);

    // Three back-to-back TLPs from fresh counters; the 16-byte window wraps on the third.
    applyReset();
    applyStimulus(3, 1'b1, 0);
    runUntilDrained(200);

    // Five-cycle stall on the HDR1 beat.
    readyMode = 2;
    applyStimulus(2, 1'b1, 0);
    runUntilDrained(300);

    // Disabled frame, then an enabled frame whose enable toggles mid-frame.
    readyMode = 0;
    applyStimulus(4, 1'b0, 1);
    applyStimulus(3, 1'b1, 1);
    runUntilDrained(300);

    // Random traffic with bubbles, back-pressure, restarts and varying destinations.
    useFixedDest     = 0;
    cfg_completer_id = 16'($urandom);
    readyMode        = 1;
    bubblePct        = 25;
    for (int i = 0; i < 300; i++) pushRandomWord();
    runUntilDrained(5000);

    // Reset during PAY, then the next frame must restart at tag 0 / offset 0.
    readyMode    = 0;
    bubblePct    = 0;
    resetOnPay   = 1;
    useFixedDest = 1;
    fixedDest    = 32'h4000_1000;
    applyStimulus(2, 1'b1, 0);
    runUntilDrained(300);
    checkOutput("reset_in_pay_hit", 64'(resetOnPay), 64'd0);
    applyStimulus(1, 1'b1, 0);
    runUntilDrained(200);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pio_tx_snoop.md
PIO_TX_SNOOP -- requirements
Module: pio_tx_snoop

Interface
REQ-001 SHALL have parameter WINDOW_BYTES, default 4096, target window size in bytes (power of two, >=8).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port sys_rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have ports s_axis_tx_tdata output 64, s_axis_tx_tkeep output 8, s_axis_tx_tlast output 1, s_axis_tx_tvalid output 1, s_axis_tx_tready input 1, s_axis_tx_tuser output 4: the PCIe AXIS TX TLP stream.
REQ-005 SHALL have port cfg_completer_id, input, 16, used as the requester ID.
REQ-006 SHALL have ports tx_enable input 1 (TLP generation enable) and dest_base input 32 (DW-aligned target base address).
REQ-007 SHALL have ports dout input 72 ({ctrl[7:0], data[63:0]}), empty input 1, and rd_en output 1: the first-word-fall-through XGMII-RX FIFO read side.

Function
REQ-008 SHALL assert rd_en combinationally only in IDLE or FRAME when empty=0; dout is valid whenever empty=0, and rd_en pops the word.
REQ-009 SHALL classify a word as START when ctrl[0]=1 and data[7:0]=8'hFB, as DATA when ctrl=8'h00, and as CTRL otherwise.
REQ-010 SHALL use states IDLE, FRAME, HDR0, HDR1, PAY.
REQ-011 IDLE: pop every word; on START, latch tx_enable into en_q and go to FRAME; otherwise stay in IDLE.
REQ-012 FRAME: on DATA, pop the word; if en_q=1, latch the data and go to HDR0; if en_q=0, discard the data and stay in FRAME.
REQ-013 FRAME: on CTRL, pop the word and go to IDLE; this drops the terminate word and any partial bytes it carries.
REQ-014 FRAME: on START, pop the word, relatch en_q, and stay in FRAME (restart).
REQ-015 HDR0 beat: tdata={DW1,DW0}; DW0=32'h4000_0002 (MWr32, 3DW, length 2); DW1={cfg_completer_id, tag[7:0], 8'hFF}; tkeep=8'hFF; tlast=0.
REQ-016 HDR1 beat: tdata={data[31:0], DW2}; DW2={addr[31:2],2'b00}; addr=dest_base+offset; tkeep=8'hFF; tlast=0.
REQ-017 PAY beat: tdata={32'h0, data[63:32]}; tkeep=8'h0F; tlast=1.
REQ-018 SHALL hold tvalid=1 in HDR0/HDR1/PAY, 0 elsewhere; each state advances only on tvalid&&tready, and tdata/tkeep/tlast SHALL stay stable while tready=0.
REQ-019 On PAY acceptance: offset<=(offset+8) mod WINDOW_BYTES, tag<=tag+1 (8-bit wrap), next state FRAME.
REQ-020 SHALL drive s_axis_tx_tuser=4'h0 and SHALL NOT pop the FIFO in HDR0/HDR1/PAY (back-pressure propagates to FIFO).
REQ-021 dest_base SHALL be sampled per TLP in HDR1; changing it mid-stream affects only later TLPs.
REQ-022 Minimum TLP spacing SHALL be 4 cycles (1 FRAME + 3 beats) with tready held 1.

Reset
REQ-023 sys_rst SHALL asynchronously force state=IDLE, tvalid=0, tlast=0, tkeep=0, tdata=0, rd_en=0, offset=0, tag=0, en_q=0.
REQ-024 Reset asserted mid-TLP SHALL abandon it with no further beats; after release, the first TLP uses offset 0 and tag 0.

Configuration
REQ-025 Macro PIO_TX_SNOOP_COUNT_EN: when defined, SHALL add output tlp_count[31:0], reset to 0, incremented on each PAY acceptance and wrapping at 2^32.
REQ-026 When PIO_TX_SNOOP_COUNT_EN is undefined, tlp_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Idle stream (dout={8'hFF,64'h0707...07}, empty=0) -> rd_en=1 every cycle, tvalid never 1.
REQ-028 START, DATA 64'h1122334455667788, terminate word; dest_base=32'h8000_0000, id=16'h0100, tready=1 -> beats {32'h0100_00FF,32'h4000_0002}, {32'h5566_7788,32'h8000_0000}, {0,32'h1122_3344} keep 0F tlast 1.
REQ-029 Frame of 3 DATA words -> addresses 8000_0000/0008/0010, tags 0/1/2; with WINDOW_BYTES=16, the third address wraps to 8000_0000.
REQ-030 tready=0 for 5 cycles during HDR1 -> beat held stable, rd_en=0, then completes; no data lost.
REQ-031 tx_enable=0 at START -> all frame words popped, no TLP; toggling tx_enable mid-frame has no effect until the next START.
REQ-032 sys_rst pulse during PAY -> tvalid=0 immediately; the next frame emits tag 0 at dest_base+0; with the macro defined, tlp_count=0 then 1.
